// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one main-memory read port between I- and D-cache line refills.
// Define RR_ARB_EN for round-robin arbitration; the default build uses fixed data-side priority.
module mem_refill_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int MEM_LAT    = 3
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          iReq,
    input  logic [31:0]                   iAddr,
    input  logic                          dReq,
    input  logic [31:0]                   dAddr,
    input  logic [31:0]                   memData,
    output logic                          memRd,
    output logic [31:0]                   memAddr,
    output logic                          iGnt,
    output logic                          dGnt,
    output logic                          fillValid,
    output logic [31:0]                   fillData,
    output logic [$clog2(LINE_WORDS)-1:0] fillIdx,
    output logic                          iDone,
    output logic                          dDone,
    output logic                          busy
);
    // state | meaning
    // IDLE  | no refill in progress; requests are sampled only here
    // FETCH | reading the line, MEM_LAT cycles per word
    // DONE  | single cycle: owner's Done pulse, grant still held
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    localparam int               IDX_W     = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LINE_WORDS - 1);
    localparam logic [3:0]       CNT_LAST  = 4'(MEM_LAT - 1);
    localparam logic [31:0]      BASE_MASK = ~32'(LINE_WORDS * 4 - 1);

    state_t           r_state;
    logic [31:0]      r_base;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_cnt;
    logic             r_igrant;
    logic             r_dgrant;
    logic             w_pick_d;
    logic             w_fetch;
    logic             w_word_end;
    logic [31:0]      w_word_off;

`ifdef RR_ARB_EN
    logic r_last_dat;   // 1 = data side won the most recent grant
    assign w_pick_d = dReq & (~iReq | ~r_last_dat);
`else
    assign w_pick_d = dReq;
`endif

    assign w_fetch    = (r_state == FETCH);
    assign w_word_end = w_fetch & (r_cnt == CNT_LAST);
    assign w_word_off = {{(30 - IDX_W){1'b0}}, r_idx, 2'b00};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_igrant <= 1'b0;
            r_dgrant <= 1'b0;
`ifdef RR_ARB_EN
            r_last_dat <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (iReq | dReq) begin
                        r_base   <= (w_pick_d ? dAddr : iAddr) & BASE_MASK;
                        r_dgrant <= w_pick_d;
                        r_igrant <= ~w_pick_d;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_state  <= FETCH;
`ifdef RR_ARB_EN
                        r_last_dat <= w_pick_d;
`endif
                    end
                end
                FETCH: begin
                    // the index wraps back to 0 on the last word since LINE_WORDS is a power of two
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_idx == IDX_LAST)
                            r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_igrant <= 1'b0;
                    r_dgrant <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign memRd     = w_fetch;
    assign memAddr   = w_fetch ? (r_base + w_word_off) : 32'h0;
    assign fillValid = w_word_end;
    assign fillData  = w_word_end ? memData : 32'h0;
    assign fillIdx   = r_idx;
    assign iGnt      = r_igrant;
    assign dGnt      = r_dgrant;
    assign iDone     = (r_state == DONE) & r_igrant;
    assign dDone     = (r_state == DONE) & r_dgrant;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: directed vectors plus randomized traffic against a transaction-level model.
// Also exercises a LINE_WORDS=2 / MEM_LAT=1 instance for the address-wrap case.
module tb_mem_refill_arbiter;
    localparam int LW = 4;
    localparam int ML = 3;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        iReq, dReq;
    logic [31:0] iAddr, dAddr, memData;
    logic        memRd, iGnt, dGnt, fillValid, iDone, dDone, busy;
    logic [31:0] memAddr, fillData;
    logic [1:0]  fillIdx;

    logic        b_iReq, b_dReq;
    logic [31:0] b_iAddr, b_dAddr, b_memData;
    logic        b_memRd, b_iGnt, b_dGnt, b_fillValid, b_iDone, b_dDone, b_busy;
    logic [31:0] b_memAddr, b_fillData;
    logic [0:0]  b_fillIdx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    mem_refill_arbiter #(.LINE_WORDS(LW), .MEM_LAT(ML)) dut_a (
        .Clk(Clk), .Rst(Rst), .iReq(iReq), .iAddr(iAddr), .dReq(dReq), .dAddr(dAddr),
        .memData(memData), .memRd(memRd), .memAddr(memAddr), .iGnt(iGnt), .dGnt(dGnt),
        .fillValid(fillValid), .fillData(fillData), .fillIdx(fillIdx),
        .iDone(iDone), .dDone(dDone), .busy(busy)
    );

    mem_refill_arbiter #(.LINE_WORDS(2), .MEM_LAT(1)) dut_b (
        .Clk(Clk), .Rst(Rst), .iReq(b_iReq), .iAddr(b_iAddr), .dReq(b_dReq), .dAddr(b_dAddr),
        .memData(b_memData), .memRd(b_memRd), .memAddr(b_memAddr), .iGnt(b_iGnt), .dGnt(b_dGnt),
        .fillValid(b_fillValid), .fillData(b_fillData), .fillIdx(b_fillIdx),
        .iDone(b_iDone), .dDone(b_dDone), .busy(b_busy)
    );

    task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [72:0] act_a();
        return {iGnt, dGnt, memRd, memAddr, fillValid, fillData, fillIdx, iDone, dDone, busy};
    endfunction

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        @(negedge Clk);
        while (busy && k < 50) begin
            next_cycle();
            @(negedge Clk);
            k++;
        end
        chk(nm, 73'(busy), 73'(0));
        next_cycle();
    endtask

    // Transaction-level reference: a refill is "k cycles since grant"; words and
    // strobes follow from k by division, and DONE is the cycle k == LW*ML.
    bit          m_act = 1'b0;
    bit          m_own_d = 1'b0;
    bit          m_last_d = 1'b0;
    int          m_k = 0;
    logic [31:0] m_base = 32'h0;

    always @(negedge Clk) begin
        logic [72:0] exp_v;
        int          word;
        logic        fv;
        logic        pick;
        exp_v = '0;
        if (!Rst && m_act) begin
            if (m_k < LW * ML) begin
                word  = m_k / ML;
                fv    = ((m_k % ML) == ML - 1);
                exp_v = {~m_own_d, m_own_d, 1'b1, m_base + 32'(4 * word), fv,
                         fv ? memData : 32'h0, 2'(word), 1'b0, 1'b0, 1'b1};
            end else begin
                exp_v = {~m_own_d, m_own_d, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, ~m_own_d, m_own_d, 1'b1};
            end
        end
        chk($sformatf("model cyc %0d", cyc), act_a(), exp_v);
        if (Rst) begin
            m_act    = 1'b0;
            m_last_d = 1'b0;
        end else if (!m_act) begin
            if (iReq || dReq) begin
`ifdef RR_ARB_EN
                pick = dReq && (!iReq || !m_last_d);
`else
                pick = dReq;
`endif
                m_act    = 1'b1;
                m_k      = 0;
                m_own_d  = pick;
                m_last_d = pick;
                m_base   = (pick ? dAddr : iAddr) & ~32'(LW * 4 - 1);
            end
        end else if (m_k == LW * ML) begin
            m_act = 1'b0;
        end else begin
            m_k++;
        end
    end

    typedef struct {
        logic        i_req;
        logic        e_gnt, e_rd, e_fv, e_done, e_busy;
        logic [31:0] e_addr;
        logic [1:0]  e_idx;
    } vec_t;

    vec_t        tbl [16];
    logic [71:0] b_exp [5];

    function automatic vec_t mk(input logic rq, input logic g, input logic rd, input logic [31:0] a,
                                input logic fv, input logic [1:0] ix, input logic dn, input logic b);
        vec_t v;
        v.i_req = rq; v.e_gnt = g; v.e_rd = rd; v.e_addr = a;
        v.e_fv = fv; v.e_idx = ix; v.e_done = dn; v.e_busy = b;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0)
            return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return $urandom;
    endfunction

    initial begin
        logic [72:0] exp_v;
        logic        ord [3];
        logic        exp_ord [3];
        int          n;
        logic        prev_busy;
        logic        i_done_seen, d_done_seen;

        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 2'd0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 2'd0, 1'b0, 1'b1);
        tbl[3]  = mk(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 2'd0, 1'b0, 1'b1);
        tbl[4]  = mk(1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 2'd1, 1'b0, 1'b1);
        tbl[5]  = mk(1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 2'd1, 1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 2'd1, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 1'b1, 1'b1, 32'h48, 1'b0, 2'd2, 1'b0, 1'b1);
        tbl[8]  = mk(1'b1, 1'b1, 1'b1, 32'h48, 1'b0, 2'd2, 1'b0, 1'b1);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 32'h48, 1'b1, 2'd2, 1'b0, 1'b1);
        tbl[10] = mk(1'b1, 1'b1, 1'b1, 32'h4C, 1'b0, 2'd3, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 32'h4C, 1'b0, 2'd3, 1'b0, 1'b1);
        tbl[12] = mk(1'b1, 1'b1, 1'b1, 32'h4C, 1'b1, 2'd3, 1'b0, 1'b1);
        tbl[13] = mk(1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 2'd0, 1'b1, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        // {dGnt, iGnt, memRd, memAddr, fillValid, fillData, fillIdx, dDone, iDone, busy}
        b_exp[0] = 72'h0;
        b_exp[1] = {1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h5A5A_0001, 1'b0, 1'b0, 1'b0, 1'b1};
        b_exp[2] = {1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h5A5A_0002, 1'b1, 1'b0, 1'b0, 1'b1};
        b_exp[3] = {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        b_exp[4] = 72'h0;

        Rst = 1'b1;
        iReq = 1'b0; dReq = 1'b0; iAddr = 32'h0; dAddr = 32'h0; memData = 32'h0;
        b_iReq = 1'b0; b_dReq = 1'b0; b_iAddr = 32'h0; b_dAddr = 32'h0; b_memData = 32'h0;
        repeat (3) next_cycle();
        @(negedge Clk);
        chk("reset outs a", act_a(), 73'(0));
        chk("reset outs b", 73'({b_dGnt, b_iGnt, b_memRd, b_memAddr, b_fillValid, b_fillIdx, b_busy}), 73'(0));
        next_cycle();
        Rst = 1'b0;
        repeat (2) next_cycle();

        // single instruction refill, cycle by cycle
        iAddr = 32'h0000_0044;
        for (int c = 0; c < 16; c++) begin
            iReq    = tbl[c].i_req;
            memData = 32'hC0DE_0000 + 32'(c);
            @(negedge Clk);
            exp_v = {tbl[c].e_gnt, 1'b0, tbl[c].e_rd, tbl[c].e_addr, tbl[c].e_fv,
                     tbl[c].e_fv ? memData : 32'h0, tbl[c].e_idx, tbl[c].e_done, 1'b0, tbl[c].e_busy};
            chk($sformatf("vec %0d", c), act_a(), exp_v);
            next_cycle();
        end

        // simultaneous requests: data first, instruction afterwards
        dReq = 1'b1; dAddr = 32'h100; iReq = 1'b1; iAddr = 32'h200;
        for (int c = 0; c < 29; c++) begin
            if (c == 14) dReq = 1'b0;
            if (c == 28) iReq = 1'b0;
            memData = $urandom;
            @(negedge Clk);
            if (c == 1)  chk("both d first", 73'({iGnt, dGnt, memAddr}), 73'({1'b0, 1'b1, 32'h100}));
            if (c == 10) chk("both d last addr", 73'(memAddr), 73'(32'h10C));
            if (c == 13) chk("both d done", 73'({dDone, iDone}), 73'(2'b10));
            if (c == 14) chk("both idle gap", 73'({iGnt, dGnt, busy}), 73'(0));
            if (c == 15) chk("both i grant", 73'({iGnt, dGnt, memAddr}), 73'({1'b1, 1'b0, 32'h200}));
            if (c == 24) chk("both i last addr", 73'(memAddr), 73'(32'h20C));
            if (c == 27) chk("both i done", 73'({iDone, dDone}), 73'(2'b10));
            next_cycle();
        end

        // three back-to-back contests
`ifdef RR_ARB_EN
        exp_ord[0] = 1'b1; exp_ord[1] = 1'b0; exp_ord[2] = 1'b1;
`else
        exp_ord[0] = 1'b1; exp_ord[1] = 1'b1; exp_ord[2] = 1'b1;
`endif
        iReq = 1'b1; dReq = 1'b1; iAddr = 32'h400; dAddr = 32'h500;
        n = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge Clk);
            if (busy && !prev_busy) begin
                ord[n] = dGnt;
                n++;
            end
            prev_busy = busy;
            next_cycle();
        end
        iReq = 1'b0; dReq = 1'b0;
        chk("contest count", 73'(n), 73'(3));
        for (int j = 0; j < 3; j++)
            if (j < n) chk($sformatf("contest %0d data won", j), 73'(ord[j]), 73'(exp_ord[j]));
        wait_idle("contest drain");

        // request dropped mid-refill still completes
        iReq = 1'b1; iAddr = 32'h604;
        for (int c = 0; c < 17; c++) begin
            if (c == 4) iReq = 1'b0;
            memData = $urandom;
            @(negedge Clk);
            if (c == 1)  chk("drop grant", 73'({iGnt, memAddr}), 73'({1'b1, 32'h600}));
            if (c == 12) chk("drop last word", 73'({fillValid, fillIdx, memAddr}), 73'({1'b1, 2'd3, 32'h60C}));
            if (c == 13) chk("drop done", 73'({iDone, iGnt}), 73'(2'b11));
            if (c >= 14) chk($sformatf("drop no regrant %0d", c), 73'({iGnt, dGnt, busy}), 73'(0));
            next_cycle();
        end

        // reset in the middle of a refill
        iReq = 1'b1; iAddr = 32'h304;
        for (int c = 0; c < 7; c++) begin
            @(negedge Clk);
            next_cycle();
        end
        Rst = 1'b1;
        @(negedge Clk);
        chk("rst mid outs", act_a(), 73'(0));
        next_cycle();
        @(negedge Clk);
        chk("rst held no done", 73'({iDone, busy}), 73'(0));
        next_cycle();
        Rst = 1'b0;
        @(negedge Clk);
        chk("rst release idle", 73'(busy), 73'(0));
        next_cycle();
        @(negedge Clk);
        chk("rst fresh refill", 73'({iGnt, memRd, memAddr, fillIdx}), 73'({1'b1, 1'b1, 32'h300, 2'd0}));
        for (int c = 11; c <= 22; c++) begin
            next_cycle();
            @(negedge Clk);
            if (c == 22) chk("rst fresh done", 73'(iDone), 73'(1));
        end
        next_cycle();
        iReq = 1'b0;
        wait_idle("rst drain");

        // MEM_LAT=1, LINE_WORDS=2 instance at the top of the address space
        b_dReq = 1'b1; b_dAddr = 32'hFFFF_FFFC;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) b_dReq = 1'b0;
            b_memData = 32'h5A5A_0000 + 32'(c);
            @(negedge Clk);
            chk($sformatf("wrap cyc %0d", c),
                73'({b_dGnt, b_iGnt, b_memRd, b_memAddr, b_fillValid, b_fillData, b_fillIdx, b_dDone, b_iDone, b_busy}),
                73'(b_exp[c]));
            next_cycle();
        end

        // randomized traffic, occasional resets
        i_done_seen = 1'b0;
        d_done_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            memData = $urandom;
            if (Rst) Rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) Rst = 1'b1;
            if (!iReq) begin
                if ($urandom_range(0, 2) == 0) begin iReq = 1'b1; iAddr = rand_addr(); end
            end else if (i_done_seen || $urandom_range(0, 49) == 0) begin
                iReq = 1'b0;
            end
            if (!dReq) begin
                if ($urandom_range(0, 2) == 0) begin dReq = 1'b1; dAddr = rand_addr(); end
            end else if (d_done_seen || $urandom_range(0, 49) == 0) begin
                dReq = 1'b0;
            end
            @(negedge Clk);
            i_done_seen = iDone;
            d_done_seen = dDone;
            next_cycle();
        end
        Rst = 1'b0; iReq = 1'b0; dReq = 1'b0;
        next_cycle();
        wait_idle("final drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_refill_arbiter.md
MEM_REFILL_ARBITER -- requirements
Module: mem_refill_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per cache-line refill; power of two, 2..16.
REQ-002 Parameter MEM_LAT, default 3, main-memory cycles per word read; range 1..15.
REQ-003 Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 iReq  input  1  instruction-side miss request; held high until iDone.
REQ-006 iAddr  input  32  instruction-side miss byte address.
REQ-007 dReq  input  1  data-side miss request; held high until dDone.
REQ-008 dAddr  input  32  data-side miss byte address.
REQ-009 memData  input  32  main-memory read data, valid in the last cycle of each word access.
REQ-010 memRd  output  1  main-memory read strobe.
REQ-011 memAddr  output  32  main-memory word byte address.
REQ-012 iGnt, dGnt  output  1 each  owner of the refill port; one-hot or both zero.
REQ-013 fillValid  output  1  fillData/fillIdx valid this cycle.
REQ-014 fillData  output  32  refill word (memData passthrough).
REQ-015 fillIdx  output  log2(LINE_WORDS)  word index within the line.
REQ-016 iDone, dDone  output  1 each  one-cycle refill-complete pulses.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, FETCH and DONE.
REQ-019 In IDLE with any request high, the next edge SHALL latch the winner's address with the low log2(LINE_WORDS)+2 bits cleared as base, set the winner's grant, clear word index and cycle counter, and enter FETCH.
REQ-020 Default arbitration: when both requests are high in IDLE, dReq SHALL win.
REQ-021 In FETCH: memRd=1 and memAddr=base+4*fillIdx; the cycle counter SHALL increment every cycle from 0 to MEM_LAT-1.
REQ-022 fillValid SHALL be 1 exactly in FETCH cycles where counter==MEM_LAT-1, with fillData=memData; the next edge SHALL reset the counter and increment fillIdx.
REQ-023 After the word with fillIdx==LINE_WORDS-1, the FSM SHALL enter DONE; fillIdx SHALL wrap to 0.
REQ-024 DONE SHALL last one cycle: the owner's Done=1, grant held, memRd=0; the next edge SHALL clear the grant and return to IDLE.
REQ-025 Requests SHALL be sampled only in IDLE; a request arriving in FETCH or DONE SHALL wait.
REQ-026 A request deasserted during FETCH SHALL NOT abort the refill; the line SHALL complete with the Done pulse.
REQ-027 Latency, defaults: request high in cycle 0 with FSM in IDLE -> grant from cycle 1; fillValid in cycles 3,6,9,12; Done in cycle 13; IDLE in cycle 14; earliest next grant in cycle 15.
REQ-028 Address arithmetic SHALL be 32-bit modulo; a base near 0xFFFFFFF0 SHALL wrap without error.

Reset
REQ-029 Rst high SHALL force IDLE immediately and zero all outputs, counter, fillIdx, base and the round-robin pointer.
REQ-030 Rst mid-FETCH SHALL abandon the refill with no Done pulse; after release, still-high requests SHALL be re-arbitrated from IDLE.

Configuration
REQ-031 Macro RR_ARB_EN defined: when both requests are high in IDLE, the side not granted last SHALL win; the last-granted pointer resets to instruction side, so the first contest goes to data.
REQ-032 RR_ARB_EN undefined: fixed data-side priority per REQ-020; the pointer SHALL not exist.

Verification
REQ-033 Reset, then iReq=1, iAddr=0x0000_0044 -> iGnt=1 from cycle 1; memAddr 0x40,0x44,0x48,0x4C; fillValid in cycles 3,6,9,12 with fillIdx 0..3; iDone in cycle 13.
REQ-034 iReq and dReq both high in cycle 0, dAddr=0x100, iAddr=0x200 -> dGnt refill of 0x100..0x10C first; iGnt from cycle 15 for 0x200..0x20C.
REQ-035 With RR_ARB_EN, both requests held continuously for three refills -> grant order data, instruction, data; without it -> data, data, data.
REQ-036 Rst asserted in cycle 7 of a refill -> all outputs 0 in the same cycle; no Done; after release with iReq=1 -> fresh refill, fillIdx restarts at 0.
REQ-037 MEM_LAT=1, LINE_WORDS=2, dAddr=0xFFFF_FFFC -> memAddr 0xFFFF_FFF8, 0xFFFF_FFFC; fillValid in cycles 1,2; dDone in cycle 3.
REQ-038 iReq dropped in cycle 4 of a refill -> refill continues; iDone in cycle 13; no new grant afterwards.
